sb3647_xbee_gbi_receiver: RTL and testbench

Receives the Xbee UART stream (115200 baud, 8N1, LSB first) on the 50 MHz fabric clock. It parses GBI report messages of the form "GBI<n>-<W>-#", for example "GBI4-D-#", and presents the decoded bin number and waste colour to the bot controller with a one-cycle valid strobe. It is the receive-side counterpart of the Xbee GBI transmitter: it decodes exactly the character set and encodings that block emits.

---
 rtl/sb3647_xbee_pkg.sv | 74 +++++++
 rtl/sb3647_uart_rx_byte.sv | 109 ++++++++++
 rtl/sb3647_xbee_gbi_receiver.sv | 131 +++++++++++++
 tb/tb_sb3647_xbee_gbi_receiver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sb3647_xbee_pkg.sv
// Shared definitions for the Xbee GBI link: bit timing, the ASCII
// characters used by GBI report messages, the waste colour encoding and
// the parser state type. Used by both the transmitter and the receiver.
package sb3647_xbee_pkg;

    // 50 MHz / 115200 baud
    localparam int BPC      = 434;
    localparam int HALF_BPC = 217;

    // Message characters
    localparam logic [7:0] ASC_G    = 8'h47;
    localparam logic [7:0] ASC_B    = 8'h42;
    localparam logic [7:0] ASC_I    = 8'h49;
    localparam logic [7:0] ASC_DASH = 8'h2D;
    localparam logic [7:0] ASC_HASH = 8'h23;
    localparam logic [7:0] ASC_M    = 8'h4D;
    localparam logic [7:0] ASC_D    = 8'h44;
    localparam logic [7:0] ASC_W    = 8'h57;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_1    = 8'h31;
    localparam logic [7:0] ASC_2    = 8'h32;
    localparam logic [7:0] ASC_3    = 8'h33;
    localparam logic [7:0] ASC_4    = 8'h34;
    localparam logic [7:0] ASC_5    = 8'h35;
    localparam logic [7:0] ASC_6    = 8'h36;
    localparam logic [7:0] ASC_7    = 8'h37;
    localparam logic [7:0] ASC_8    = 8'h38;
    localparam logic [7:0] ASC_9    = 8'h39;

    // Waste colour encoding
    localparam logic [1:0] COL_M = 2'd0;
    localparam logic [1:0] COL_D = 2'd1;
    localparam logic [1:0] COL_W = 2'd2;

    typedef enum logic [2:0] {
        P_G, P_B, P_I, P_NUM, P_DASH1, P_TYPE, P_DASH2, P_HASH
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // Bin digits are '1'..'9'; '0' is not a legal bin character.
    function automatic logic is_bin_char(input logic [7:0] b);
        return (b >= ASC_1) && (b <= ASC_9);
    endfunction

    // '1'..'8' map to 1..8, '9' is carried as 0000.
    function automatic logic [3:0] bin_code(input logic [7:0] b);
        return (b == ASC_9) ? 4'd0 : b[3:0];
    endfunction

    function automatic logic is_colour_char(input logic [7:0] b);
        return (b == ASC_M) || (b == ASC_D) || (b == ASC_W);
    endfunction

    function automatic logic [1:0] colour_code(input logic [7:0] b);
        logic [1:0] c;
        c = COL_M;
        if (b == ASC_D) begin
            c = COL_D;
        end else if (b == ASC_W) begin
            c = COL_W;
        end
        return c;
    endfunction

    // A 'G' arriving mid-message is taken as the start of a new one.
    function automatic parser_state_t resync_state(input logic [7:0] b);
        return (b == ASC_G) ? P_B : P_G;
    endfunction

endpackage

// File: rtl/sb3647_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, start/data/stop bit FSM and
// stop-bit framing check. Accepts stop periods longer than one bit.
module sb3647_uart_rx_byte #(
    parameter int BPC      = sb3647_xbee_pkg::BPC,
    parameter int HALF_BPC = sb3647_xbee_pkg::HALF_BPC
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic       byte_bad,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    import sb3647_xbee_pkg::*;

    localparam logic [15:0] HALF_LAST = 16'(HALF_BPC - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BPC - 1);

    logic [1:0]  sync;
    logic [1:0]  fill;
    logic        rx_s;
    logic        armed;
    logic        stop_tick;
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    assign rx_s = sync[1];

    // byte_valid and byte_bad are single-cycle strobes in the cycle the
    // stop bit is sampled; there is no back-pressure, so the consumer must
    // act on every strobe. byte_data is stable while either strobe is high.
    assign stop_tick  = (state == RX_STOP) && (cnt == BIT_LAST);
    assign byte_valid = stop_tick && rx_s;
    assign byte_bad   = stop_tick && !rx_s;
    assign byte_data  = shreg;

    // Two-stage synchronizer for rx, plus a fill marker that shows when the
    // synchronizer holds real line samples rather than its reset value.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            fill <= 2'b00;
        end else begin
            sync <= {sync[0], rx};
            fill <= {fill[0], 1'b1};
        end
    end

    // Byte receiver FSM. A start is only taken after the line has been seen
    // high in IDLE (armed), so a line stuck low never starts a frame.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (armed && !rx_s) begin
                        armed <= 1'b0;
                        state <= RX_START;
                    end else if (fill[1] && rx_s) begin
                        armed <= 1'b1;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        frame_err <= !rx_s;
                        state     <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sb3647_xbee_gbi_receiver.sv
// Parses "GBI<n>-<W>-#" report messages from the Xbee UART stream and
// presents the decoded bin number and waste colour with a valid strobe.
module sb3647_xbee_gbi_receiver #(
    parameter int BPC      = sb3647_xbee_pkg::BPC,
    parameter int HALF_BPC = sb3647_xbee_pkg::HALF_BPC
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] bin_number,
    output logic [1:0] colour,
    output logic       msg_valid,
    output logic       msg_error,
    output logic       frame_err
);
    import sb3647_xbee_pkg::*;

    logic          byte_valid;
    logic          byte_bad;
    logic [7:0]    byte_data;
    parser_state_t pstate;
    logic [3:0]    pend_bin;
    logic [1:0]    pend_col;

    sb3647_uart_rx_byte #(
        .BPC      (BPC),
        .HALF_BPC (HALF_BPC)
    ) u_rx (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_bad   (byte_bad),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Message parser. Pending bin/colour are held until the closing '#',
    // so a partial or broken message never touches the outputs.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pstate     <= P_G;
            pend_bin   <= '0;
            pend_col   <= COL_M;
            bin_number <= '0;
            colour     <= COL_M;
            msg_valid  <= 1'b0;
            msg_error  <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            msg_error <= 1'b0;
            if (byte_bad) begin
                if (pstate != P_G) begin
                    msg_error <= 1'b1;
                end
                pstate <= P_G;
            end else if (byte_valid) begin
                case (pstate)
                    P_G: begin
                        if (byte_data == ASC_G) begin
                            pstate <= P_B;
                        end
                    end
                    P_B: begin
                        if (byte_data == ASC_B) begin
                            pstate <= P_I;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_I: begin
                        if (byte_data == ASC_I) begin
                            pstate <= P_NUM;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_NUM: begin
                        if (is_bin_char(byte_data)) begin
                            pend_bin <= bin_code(byte_data);
                            pstate   <= P_DASH1;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_DASH1: begin
                        if (byte_data == ASC_DASH) begin
                            pstate <= P_TYPE;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_TYPE: begin
                        if (is_colour_char(byte_data)) begin
                            pend_col <= colour_code(byte_data);
                            pstate   <= P_DASH2;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_DASH2: begin
                        if (byte_data == ASC_DASH) begin
                            pstate <= P_HASH;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    P_HASH: begin
                        if (byte_data == ASC_HASH) begin
                            bin_number <= pend_bin;
                            colour     <= pend_col;
                            msg_valid  <= 1'b1;
                            pstate     <= P_G;
                        end else begin
                            msg_error <= 1'b1;
                            pstate    <= resync_state(byte_data);
                        end
                    end
                    default: pstate <= P_G;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb3647_xbee_gbi_receiver.sv
// Bench for the Xbee GBI receiver: table of messages with expected pulse
// counts and outputs, plus hand-written glitch, framing and reset sequences.
module tb_sb3647_xbee_gbi_receiver;

    // Short bit period keeps the run brief; the RTL is parameterised.
    localparam int BPC      = 16;
    localparam int HALF_BPC = 8;
    // rx fall to output pulse: 3 clocks to start detection, then
    // HALF_BPC + 9*BPC to the stop sample (output registered on that edge).
    localparam int LAT      = HALF_BPC + 9 * BPC + 3;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [3:0] bin_number;
    logic [1:0] colour;
    logic       msg_valid;
    logic       msg_error;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int n_valid = 0;
    int n_error = 0;
    int n_ferr = 0;
    int width_err = 0;
    int change_err = 0;
    int last_valid_cyc = 0;
    int last_ferr_cyc = 0;
    int last_start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_error = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [3:0] prev_bin = 4'd0;
    logic [1:0] prev_col = 2'd0;

    typedef struct {
        logic [79:0] text;
        int          len;
        int          stops;
        int          exp_valid;
        int          exp_error;
        int          exp_ferr;
        logic [3:0]  exp_bin;
        logic [1:0]  exp_col;
    } vec_t;

    vec_t vecs[10];

    sb3647_xbee_gbi_receiver #(
        .BPC      (BPC),
        .HALF_BPC (HALF_BPC)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .rx         (rx),
        .bin_number (bin_number),
        .colour     (colour),
        .msg_valid  (msg_valid),
        .msg_error  (msg_error),
        .frame_err  (frame_err)
    );

    // clock and cycle counter
    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // pulse monitor: counts rising edges, flags pulses wider than one
    // clock and output changes without msg_valid
    always @(negedge clk_50M) begin
        if (msg_valid && !prev_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (msg_error && !prev_error) n_error <= n_error + 1;
        if (frame_err && !prev_ferr) begin
            n_ferr        <= n_ferr + 1;
            last_ferr_cyc <= cyc;
        end
        if ((msg_valid && prev_valid) || (msg_error && prev_error) || (frame_err && prev_ferr))
            width_err <= width_err + 1;
        if (rst_n && !msg_valid && (bin_number != prev_bin || colour != prev_col))
            change_err <= change_err + 1;
        prev_valid <= msg_valid;
        prev_error <= msg_error;
        prev_ferr  <= frame_err;
        prev_bin   <= bin_number;
        prev_col   <= colour;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drivers: every call starts and ends 1 time unit after a posedge
    task automatic hold_bit(input logic b);
        rx = b;
        repeat (BPC) @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int stops, input logic stop_val);
        last_start_cyc = cyc;
        hold_bit(1'b0);
        for (int k = 0; k < 8; k++) hold_bit(d[k]);
        hold_bit(stop_val);
        for (int k = 1; k < stops; k++) hold_bit(1'b1);
        rx = 1'b1;
    endtask

    task automatic send_text(input logic [79:0] text, input int len, input int stops);
        for (int i = 0; i < len; i++) send_byte(text[8*(len-1-i) +: 8], stops, 1'b1);
    endtask

    task automatic run_vec(input int i);
        int v0, e0, f0;
        v0 = n_valid;
        e0 = n_error;
        f0 = n_ferr;
        send_text(vecs[i].text, vecs[i].len, vecs[i].stops);
        idle(2 * BPC);
        check($sformatf("v%0d msg_valid count", i), n_valid - v0, vecs[i].exp_valid);
        check($sformatf("v%0d msg_error count", i), n_error - e0, vecs[i].exp_error);
        check($sformatf("v%0d frame_err count", i), n_ferr - f0, vecs[i].exp_ferr);
        check($sformatf("v%0d bin_number", i), bin_number, vecs[i].exp_bin);
        check($sformatf("v%0d colour", i), colour, vecs[i].exp_col);
    endtask

    initial begin
        int v0, e0, f0;
        logic [7:0] ch_i;

        //            text          len st  v  e  f  bin    col
        vecs[0] = '{"GBI4-D-#",    8, 1, 1, 0, 0, 4'd4, 2'd1};
        vecs[1] = '{"GBI9-W-#\n",  9, 2, 1, 0, 0, 4'd0, 2'd2};
        vecs[2] = '{"GBI1-M-#",    8, 2, 1, 0, 0, 4'd1, 2'd0};
        vecs[3] = '{"GBX",         3, 1, 0, 1, 0, 4'd1, 2'd0};
        vecs[4] = '{"GBI2-M-#",    8, 1, 1, 0, 0, 4'd2, 2'd0};
        vecs[5] = '{"GBI5-D-#",    8, 1, 1, 0, 0, 4'd5, 2'd1};
        vecs[6] = '{"GBI0-M-#",    8, 1, 0, 1, 0, 4'd5, 2'd1};
        vecs[7] = '{"GBI3-Q-#",    8, 1, 0, 1, 0, 4'd5, 2'd1};
        vecs[8] = '{"GGBI7-W-#",   9, 1, 1, 1, 0, 4'd7, 2'd2};
        vecs[9] = '{"GBI8-D-#",    8, 1, 1, 0, 0, 4'd8, 2'd1};

        // reset
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(posedge clk_50M);
        #1;
        check("reset bin_number", bin_number, 0);
        check("reset colour", colour, 0);
        check("reset msg_valid", msg_valid, 0);
        check("reset msg_error", msg_error, 0);
        check("reset frame_err", frame_err, 0);
        rst_n = 1'b1;
        idle(BPC);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
            if (i == 0) check("v0 msg_valid latency", last_valid_cyc - last_start_cyc, LAT);
        end

        // short low glitch: false start, nothing received
        v0 = n_valid; e0 = n_error; f0 = n_ferr;
        rx = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        idle(3 * BPC);
        check("glitch msg_valid count", n_valid - v0, 0);
        check("glitch msg_error count", n_error - e0, 0);
        check("glitch frame_err count", n_ferr - f0, 0);

        // stop bit low with the parser idle: frame_err only
        v0 = n_valid; e0 = n_error; f0 = n_ferr;
        send_byte(8'h47, 1, 1'b0);
        idle(2 * BPC);
        check("badstop frame_err count", n_ferr - f0, 1);
        check("badstop msg_error count", n_error - e0, 0);
        check("badstop msg_valid count", n_valid - v0, 0);
        check("badstop frame_err latency", last_ferr_cyc - last_start_cyc, LAT);

        // stop bit low mid-message: frame_err plus msg_error, parser back to G
        v0 = n_valid; e0 = n_error; f0 = n_ferr;
        send_text("GB", 2, 1);
        send_byte(8'h49, 1, 1'b0);
        idle(2 * BPC);
        check("midmsg frame_err count", n_ferr - f0, 1);
        check("midmsg msg_error count", n_error - e0, 1);
        v0 = n_valid; e0 = n_error;
        send_text("I6-M-#", 6, 1);
        idle(2 * BPC);
        check("tail ignored msg_valid count", n_valid - v0, 0);
        check("tail ignored msg_error count", n_error - e0, 0);
        check("tail ignored bin_number", bin_number, 2);

        // reset in the middle of the third byte, line left low across release
        v0 = n_valid; e0 = n_error; f0 = n_ferr;
        send_text("GB", 2, 1);
        ch_i = 8'h49;
        hold_bit(1'b0);
        hold_bit(ch_i[0]);
        hold_bit(ch_i[1]);
        rx = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        check("midreset bin_number", bin_number, 0);
        check("midreset colour", colour, 0);
        repeat (3) @(posedge clk_50M);
        #1 rst_n = 1'b1;
        repeat (12 * BPC) @(posedge clk_50M);
        #1;
        check("held low frame_err count", n_ferr - f0, 0);
        check("held low msg_valid count", n_valid - v0, 0);
        check("held low msg_error count", n_error - e0, 0);
        idle(2 * BPC);

        for (int i = 5; i < 10; i++) run_vec(i);

        check("pulse width violations", width_err, 0);
        check("outputs changed without msg_valid", change_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
